ram_arbiter: RTL and testbench

- Two-requester arbiter that shares one single-port synchronous RAM (RAM_sync) between the CPU (port A) and a secondary master (port B, video scan or DMA).
- Selects one requester per cycle with round-robin fairness and an optional bounded lock for back-to-back bursts.
- Drives the RAM address, data and write-enable, and returns read data with a valid strobe to the winning port.
- Sits between the CPU/peripheral bus and the RAM_sync instance.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_arb_lock_ctr.sv | 46 ++++
 rtl/ram_arbiter.sv | 103 ++++++++++
 tb/tb_ram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Wide enough for MAX_LOCK up to 255.
  localparam int LOCK_CNT_W = 8;

  function automatic owner_e port2owner(input logic port);
    return (port == PORT_B) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/ram_arb_lock_ctr.sv
// Lock owner register plus saturating consecutive-grant counter.
// expired_o flags that the current owner has used up its MAX_LOCK grants.
module ram_arb_lock_ctr
  import ram_arb_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   gnt_vld_i,
  input  logic   gnt_port_i,
  input  logic   gnt_lock_i,
  output owner_e owner_o,
  output logic   expired_o
);

  owner_e                owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  owner_e                gnt_owner;

  assign gnt_owner = port2owner(gnt_port_i);
  assign expired_o = (owner_q != OWN_NONE) && (cnt_q >= LOCK_CNT_W'(MAX_LOCK));
  assign owner_o   = owner_q;

  // A fresh lock (new owner, or re-lock after expiry) restarts the count at 1.
  always_comb begin
    owner_d = OWN_NONE;
    cnt_d   = '0;
    if (gnt_vld_i && gnt_lock_i) begin
      owner_d = gnt_owner;
      if ((gnt_owner == owner_q) && !expired_o) cnt_d = cnt_q + LOCK_CNT_W'(1);
      else                                      cnt_d = LOCK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with bounded lock sharing one single-port sync RAM
// between port A (CPU) and port B (video/DMA); reads return one cycle later.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic                  lock_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic                  gnt_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic                  rvalid_a,
  input  logic                  req_b,
  input  logic                  lock_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic                  gnt_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  rvalid_b,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  owner_e owner;
  logic   expired;
  logic   fav_a, fav_b;
  logic   win_a, win_b;
  logic   last_grant_q, last_grant_d;
  logic   rvalid_a_q, rvalid_b_q;

  assign fav_a = (owner == OWN_A) && !expired && req_a;
  assign fav_b = (owner == OWN_B) && !expired && req_b;

  // Lock owner first, then a lone requester, then round-robin on contention.
  always_comb begin
    win_a = 1'b0;
    win_b = 1'b0;
    if (!reset) begin
      if (fav_a)                win_a = 1'b1;
      else if (fav_b)           win_b = 1'b1;
      else if (req_a && req_b) begin
        if (last_grant_q == PORT_B) win_a = 1'b1;
        else                        win_b = 1'b1;
      end
      else if (req_a)           win_a = 1'b1;
      else if (req_b)           win_b = 1'b1;
    end
  end

  assign gnt_a = win_a;
  assign gnt_b = win_b;

  // Idle leaves port A's address/data on the bus with the write strobe low.
  assign ram_addr = win_b ? addr_b : addr_a;
  assign ram_din  = win_b ? din_b  : din_a;
  assign ram_we   = (win_a & we_a) | (win_b & we_b);

  always_comb begin
    last_grant_d = last_grant_q;
    if (win_a)      last_grant_d = PORT_A;
    else if (win_b) last_grant_d = PORT_B;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= PORT_B;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rvalid_a_q   <= win_a & ~we_a;
      rvalid_b_q   <= win_b & ~we_b;
    end
  end

  ram_arb_lock_ctr #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock (
    .clk        (clk),
    .rst        (reset),
    .gnt_vld_i  (win_a | win_b),
    .gnt_port_i (win_b ? PORT_B : PORT_A),
    .gnt_lock_i (win_b ? lock_b : lock_a),
    .owner_o    (owner),
    .expired_o  (expired)
  );

  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign rdata_a  = ram_dout;
  assign rdata_b  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, abstract reference model,
// directed table, lock/reset sequences and randomized traffic.
module tb_ram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_a, lock_a, we_a, req_b, lock_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout = '0;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en)      ram[pre_addr] <= pre_data;
    else if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .lock_a(lock_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .gnt_a(gnt_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .lock_b(lock_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .gnt_b(gnt_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // Reference model: who holds a lock streak, how long, who won last.
  int            m_own = 0, m_streak = 0, m_last = 2, m_win = 0;
  bit            m_pa = 0, m_pb = 0;
  logic [DW-1:0] m_da = '0, m_db = '0;
  logic [DW-1:0] mm [int];
  int            wait_a = 0, wait_b = 0;
  int            errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : '0;
  endfunction

  function automatic int model_winner();
    bit ra, rb, own_req;
    ra = req_a; rb = req_b;
    if (reset) return 0;
    own_req = (m_own == 1) ? ra : (m_own == 2) ? rb : 1'b0;
    if (m_own != 0 && own_req && m_streak < ML) return m_own;
    if (ra && rb) return (m_last == 1) ? 2 : 1;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  task automatic sample();
    logic exp_we;
    @(negedge clk);
    m_win  = model_winner();
    exp_we = (m_win == 1) ? we_a : (m_win == 2) ? we_b : 1'b0;
    chk("gnt_a", 32'(gnt_a), 32'(m_win == 1));
    chk("gnt_b", 32'(gnt_b), 32'(m_win == 2));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("ram_addr", 32'(ram_addr), 32'((m_win == 2) ? addr_b : addr_a));
    chk("ram_din", 32'(ram_din), 32'((m_win == 2) ? din_b : din_a));
    chk("rvalid_a", 32'(rvalid_a), 32'(m_pa && !reset));
    chk("rvalid_b", 32'(rvalid_b), 32'(m_pb && !reset));
    if (m_pa && !reset) chk("rdata_a", 32'(rdata_a), 32'(m_da));
    if (m_pb && !reset) chk("rdata_b", 32'(rdata_b), 32'(m_db));
    if (m_win == 1) chk("wait_a_bound", 32'(wait_a <= ML + 1), 32'd1);
    if (m_win == 2) chk("wait_b_bound", 32'(wait_b <= ML + 1), 32'd1);
  endtask

  task automatic advance();
    bit lk;
    @(posedge clk);
    if (reset) begin
      m_own = 0; m_streak = 0; m_last = 2; m_pa = 0; m_pb = 0;
      wait_a = 0; wait_b = 0;
    end else begin
      m_pa = (m_win == 1) && !we_a;
      m_pb = (m_win == 2) && !we_b;
      if (m_pa) m_da = mrd(addr_a);
      if (m_pb) m_db = mrd(addr_b);
      if (m_win == 1 && we_a) mm[int'(addr_a)] = din_a;
      if (m_win == 2 && we_b) mm[int'(addr_b)] = din_b;
      wait_a = (req_a && m_win != 1) ? wait_a + 1 : 0;
      wait_b = (req_b && m_win != 2) ? wait_b + 1 : 0;
      lk = (m_win == 1) ? lock_a : (m_win == 2) ? lock_b : 1'b0;
      if (m_win != 0 && lk) begin
        m_streak = (m_own == m_win && m_streak < ML) ? m_streak + 1 : 1;
        m_own    = m_win;
      end else begin
        m_own = 0; m_streak = 0;
      end
      if (m_win != 0) m_last = m_win;
    end
    #1;
  endtask

  task automatic set_a(input logic r, input logic l, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_a = r; lock_a = l; we_a = w; addr_a = a; din_a = d;
  endtask

  task automatic set_b(input logic r, input logic l, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_b = r; lock_b = l; we_b = w; addr_b = a; din_b = d;
  endtask

  typedef struct {
    logic ra, wa; logic [AW-1:0] aa; logic [DW-1:0] da;
    logic rb, wb; logic [AW-1:0] ab; logic [DW-1:0] db;
    logic eg_a, eg_b, ev_a, ev_b; logic [DW-1:0] ed;
  } vec_t;

  function automatic vec_t mkv(
    input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
    input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
    input logic eg_a, input logic eg_b, input logic ev_a, input logic ev_b,
    input logic [DW-1:0] ed);
    vec_t v;
    v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
    v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
    v.eg_a = eg_a; v.eg_b = eg_b; v.ev_a = ev_a; v.ev_b = ev_b; v.ed = ed;
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    int first_a;
    reset = 1'b1;
    set_a(0, 0, 0, '0, '0);
    set_b(0, 0, 0, '0, '0);
    #1;

    // Preload RAM while the arbiter is held in reset.
    pre_en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      case (i)
        0:       begin pre_addr = 16'h0010; pre_data = 16'hBEEF; end
        1:       begin pre_addr = 16'h0011; pre_data = 16'hCAFE; end
        2:       begin pre_addr = 16'h0020; pre_data = 16'h0000; end
        default: begin pre_addr = 16'(16'h0040 + i - 3); pre_data = 16'(16'hA000 + i); end
      endcase
      mm[int'(pre_addr)] = pre_data;
      sample();
      advance();
    end
    pre_en = 1'b0;
    reset  = 1'b0;

    // Directed table: single read, round-robin, write-then-read.
    tbl[0] = mkv(1, 0, 16'h0010, 0,       0, 0, 0,        0, 1, 0, 0, 0, 16'h0000);
    tbl[1] = mkv(0, 0, 0,        0,       0, 0, 0,        0, 0, 0, 1, 0, 16'hBEEF);
    tbl[2] = mkv(1, 0, 16'h0010, 0,       1, 0, 16'h0011, 0, 0, 1, 0, 0, 16'h0000);
    tbl[3] = mkv(1, 0, 16'h0010, 0,       1, 0, 16'h0011, 0, 1, 0, 0, 1, 16'hCAFE);
    tbl[4] = mkv(1, 0, 16'h0010, 0,       1, 0, 16'h0011, 0, 0, 1, 1, 0, 16'hBEEF);
    tbl[5] = mkv(1, 0, 16'h0010, 0,       1, 0, 16'h0011, 0, 1, 0, 0, 1, 16'hCAFE);
    tbl[6] = mkv(1, 1, 16'h0020, 16'h1234, 0, 0, 0,       0, 1, 0, 1, 0, 16'hBEEF);
    tbl[7] = mkv(0, 0, 0,        0,       1, 0, 16'h0020, 0, 0, 1, 0, 0, 16'h0000);
    tbl[8] = mkv(0, 0, 0,        0,       0, 0, 0,        0, 0, 0, 0, 1, 16'h1234);
    for (int i = 0; i < 9; i++) begin
      set_a(tbl[i].ra, 1'b0, tbl[i].wa, tbl[i].aa, tbl[i].da);
      set_b(tbl[i].rb, 1'b0, tbl[i].wb, tbl[i].ab, tbl[i].db);
      sample();
      chk($sformatf("tbl%0d_gnt_a", i), 32'(gnt_a), 32'(tbl[i].eg_a));
      chk($sformatf("tbl%0d_gnt_b", i), 32'(gnt_b), 32'(tbl[i].eg_b));
      chk($sformatf("tbl%0d_rvalid_a", i), 32'(rvalid_a), 32'(tbl[i].ev_a));
      chk($sformatf("tbl%0d_rvalid_b", i), 32'(rvalid_b), 32'(tbl[i].ev_b));
      if (tbl[i].ev_a) chk($sformatf("tbl%0d_rdata_a", i), 32'(rdata_a), 32'(tbl[i].ed));
      if (tbl[i].ev_b) chk($sformatf("tbl%0d_rdata_b", i), 32'(rdata_b), 32'(tbl[i].ed));
      advance();
    end

    // B holds a lock; A joins one cycle later and must win after ML grants.
    first_a = -1;
    for (int k = 0; k < 7; k++) begin
      set_b(k < 6, 1'b1, 1'b0, 16'h0011, '0);
      set_a(k >= 1 && first_a < 0 || k == 6, 1'b0, 1'b0, 16'h0010, '0);
      sample();
      if (k <= ML) begin
        chk($sformatf("lock_k%0d_gnt_b", k), 32'(gnt_b), 32'(k < ML));
        chk($sformatf("lock_k%0d_gnt_a", k), 32'(gnt_a), 32'(k == ML));
      end
      if (k == 6) chk("owner_drop_gnt_a", 32'(gnt_a), 32'd1);
      if (gnt_a && first_a < 0) first_a = k;
      advance();
    end
    chk("lock_a_first_grant", 32'(first_a), 32'(ML));

    // Reset right after a locked read grant to B.
    set_a(0, 0, 0, '0, '0);
    set_b(1, 1, 0, 16'h0011, '0);
    sample();
    chk("pre_rst_gnt_b", 32'(gnt_b), 32'd1);
    advance();
    reset = 1'b1;
    set_a(1, 0, 0, 16'h0010, '0);
    set_b(1, 1, 0, 16'h0011, '0);
    sample();
    chk("rst_rvalid_b_drop", 32'(rvalid_b), 32'd0);
    chk("rst_gnt_a", 32'(gnt_a), 32'd0);
    chk("rst_gnt_b", 32'(gnt_b), 32'd0);
    advance();
    sample();
    advance();
    reset = 1'b0;
    sample();
    chk("post_rst_first_a", 32'(gnt_a), 32'd1);
    advance();

    // Idle then read back.
    set_a(0, 0, 0, '0, '0);
    set_b(0, 0, 0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("idle_we", 32'(ram_we), 32'd0);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      set_a(1, 0, 0, (i == 0) ? 16'h0010 : (i == 1) ? 16'h0020 : 16'h0011, '0);
      sample();
      advance();
      set_a(0, 0, 0, '0, '0);
      sample();
      chk($sformatf("readback%0d", i), 32'(rdata_a),
          32'((i == 0) ? 16'hBEEF : (i == 1) ? 16'h1234 : 16'hCAFE));
      advance();
    end

    // Randomized traffic; a port keeps its request until the model grants it.
    for (int i = 0; i < 400; i++) begin
      if (!req_a || m_win == 1)
        set_a($urandom_range(0, 3) != 0, 1'b0, 1'($urandom_range(0, 1)),
              16'(16'h0040 + $urandom_range(0, 15)), 16'($urandom));
      if (!req_b || m_win == 2)
        set_b($urandom_range(0, 3) != 0, 1'b0, 1'($urandom_range(0, 1)),
              16'(16'h0040 + $urandom_range(0, 15)), 16'($urandom));
      lock_a = $urandom_range(0, 2) != 0;
      lock_b = $urandom_range(0, 2) != 0;
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
